mux_n_registrado: RTL and testbench

- Parametrised successor to the datapath selectors: an N-input, W-bit multiplexer with a registered output and valid/ready handshaking on both sides.
- Two modes:
  - Direct mode: the channel is picked by `selecao`.
  - Round-robin mode: the block arbitrates among the valid inputs.
- Sits between producers (register file, ALU, memory read-back) and a consumer stage that may stall.
- Out-of-range selects raise a sticky error instead of silently driving zero.

---
 rtl/mux_n_registrado_pkg.sv | 18 +
 rtl/mux_n_registrado_arbitro_rr.sv | 41 ++++
 rtl/mux_n_registrado.sv | 139 +++++++++++++
 tb/tb_mux_n_registrado.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_n_registrado_pkg.sv
// Shared definitions for the registered N-input multiplexer and its arbiter.
//   modo_e      : channel selection mode (direct select / round-robin)
//   clog2_min1  : select width helper, never returns less than 1
package mux_n_registrado_pkg;

  typedef enum logic {
    MODO_DIRETO      = 1'b0,
    MODO_ROUND_ROBIN = 1'b1
  } modo_e;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/mux_n_registrado_arbitro_rr.sv
// Round-robin arbiter: grants the first requesting channel found scanning
// from ptr+1 upwards, modulo ENTRADAS.
//   requisicoes  : per-channel request
//   ptr          : last granted channel (scan starts one past it)
//   grant        : one-hot grant
//   indice       : encoded index of the granted channel
//   grant_valido : some channel was granted
module arbitro_rr
  import mux_n_registrado_pkg::*;
#(
  parameter  int ENTRADAS    = 3,
  localparam int LARGURA_SEL = clog2_min1(ENTRADAS)
) (
  input  logic [ENTRADAS-1:0]    requisicoes,
  input  logic [LARGURA_SEL-1:0] ptr,
  output logic [ENTRADAS-1:0]    grant,
  output logic [LARGURA_SEL-1:0] indice,
  output logic                   grant_valido
);

  // Scan offsets from farthest to nearest so the nearest requester,
  // written last, wins.
  always_comb begin
    grant        = '0;
    indice       = '0;
    grant_valido = 1'b0;
    for (int unsigned k = ENTRADAS; k >= 1; k--) begin
      int unsigned                c;
      logic [LARGURA_SEL-1:0]     c_idx;
      c     = (32'(ptr) + k) % 32'(ENTRADAS);
      c_idx = LARGURA_SEL'(c);
      if (requisicoes[c_idx]) begin
        grant        = '0;
        grant[c_idx] = 1'b1;
        indice       = c_idx;
        grant_valido = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_n_registrado.sv
// N-input, W-bit multiplexer with a registered output and valid/ready
// handshaking on both sides. Direct mode picks the channel by selecao;
// round-robin mode arbitrates among valid channels.
//   clock, reset        : rising-edge clock, async active-low reset
//   modo, selecao       : mode and direct-mode channel index
//   entradas            : flattened channel data, ch i at [i*LARGURA +: LARGURA]
//   entrada_valida/_pronta : per-channel input handshake (pronta one-hot or zero)
//   saida, saida_valida, saida_pronta : registered output handshake
//   canal_saida         : channel index of the word in saida
//   erro_selecao, limpa_erro : sticky out-of-range select flag and its clear
module mux_n_registrado
  import mux_n_registrado_pkg::*;
#(
  parameter  int LARGURA     = 32,
  parameter  int ENTRADAS    = 3,
  localparam int LARGURA_SEL = clog2_min1(ENTRADAS)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         modo,
  input  logic [LARGURA_SEL-1:0]       selecao,
  input  logic [ENTRADAS*LARGURA-1:0]  entradas,
  input  logic [ENTRADAS-1:0]          entrada_valida,
  output logic [ENTRADAS-1:0]          entrada_pronta,
  output logic [LARGURA-1:0]           saida,
  output logic                         saida_valida,
  input  logic                         saida_pronta,
  output logic [LARGURA_SEL-1:0]       canal_saida,
  output logic                         erro_selecao,
  input  logic                         limpa_erro
);

  logic [LARGURA-1:0]     saida_q, saida_d;
  logic                   saida_valida_q, saida_valida_d;
  logic [LARGURA_SEL-1:0] canal_q, canal_d;
  logic                   erro_q, erro_d;
  logic [LARGURA_SEL-1:0] ptr_q, ptr_d;

  logic [ENTRADAS-1:0]    rr_grant;
  logic [LARGURA_SEL-1:0] rr_indice;
  logic                   rr_valido;

  logic [ENTRADAS-1:0]    dir_grant;
  logic [LARGURA_SEL-1:0] dir_indice;
  logic                   dir_valido;
  logic                   sel_fora;

  logic                   modo_rr;
  logic [ENTRADAS-1:0]    grant_oh;
  logic [LARGURA_SEL-1:0] grant_indice;
  logic                   grant_valido;
  logic                   aceita;
  logic                   transfere;
  logic [LARGURA-1:0]     dados;

  arbitro_rr #(
    .ENTRADAS(ENTRADAS)
  ) u_arbitro (
    .requisicoes (entrada_valida),
    .ptr         (ptr_q),
    .grant       (rr_grant),
    .indice      (rr_indice),
    .grant_valido(rr_valido)
  );

  // Direct-mode decode; a select matching no channel index is out of range.
  always_comb begin
    dir_grant  = '0;
    dir_indice = '0;
    dir_valido = 1'b0;
    sel_fora   = 1'b1;
    for (int unsigned i = 0; i < ENTRADAS; i++) begin
      if (selecao == LARGURA_SEL'(i)) begin
        sel_fora = 1'b0;
        if (entrada_valida[i]) begin
          dir_grant[i] = 1'b1;
          dir_indice   = LARGURA_SEL'(i);
          dir_valido   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    modo_rr      = (modo_e'(modo) == MODO_ROUND_ROBIN);
    grant_oh     = modo_rr ? rr_grant  : dir_grant;
    grant_indice = modo_rr ? rr_indice : dir_indice;
    grant_valido = modo_rr ? rr_valido : dir_valido;

    aceita    = !saida_valida_q || saida_pronta;
    // Gating with reset keeps every ready low while reset is asserted.
    transfere = reset && aceita && grant_valido;

    entrada_pronta = transfere ? grant_oh : '0;

    dados = '0;
    for (int unsigned i = 0; i < ENTRADAS; i++) begin
      if (grant_indice == LARGURA_SEL'(i)) dados = entradas[i*LARGURA +: LARGURA];
    end

    saida_d        = saida_q;
    saida_valida_d = saida_valida_q;
    canal_d        = canal_q;
    ptr_d          = ptr_q;
    if (transfere) begin
      saida_d        = dados;
      canal_d        = grant_indice;
      saida_valida_d = 1'b1;
      if (modo_rr) ptr_d = grant_indice;
    end else if (saida_valida_q && saida_pronta) begin
      saida_valida_d = 1'b0;
    end

    // A new error wins over a simultaneous clear.
    erro_d = (!modo_rr && sel_fora && (|entrada_valida)) || (erro_q && !limpa_erro);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      saida_q        <= '0;
      saida_valida_q <= 1'b0;
      canal_q        <= '0;
      erro_q         <= 1'b0;
      ptr_q          <= LARGURA_SEL'(ENTRADAS - 1);
    end else begin
      saida_q        <= saida_d;
      saida_valida_q <= saida_valida_d;
      canal_q        <= canal_d;
      erro_q         <= erro_d;
      ptr_q          <= ptr_d;
    end
  end

  assign saida        = saida_q;
  assign saida_valida = saida_valida_q;
  assign canal_saida  = canal_q;
  assign erro_selecao = erro_q;

endmodule

// File: tb/tb_mux_n_registrado.sv
module tb_mux_n_registrado;

  localparam int W    = 32;
  localparam int N    = 3;
  localparam int SELW = 2;

  logic            clock = 1'b0;
  logic            reset;
  logic            modo;
  logic [SELW-1:0] selecao;
  logic [N*W-1:0]  entradas;
  logic [N-1:0]    entrada_valida;
  logic [N-1:0]    entrada_pronta;
  logic [W-1:0]    saida;
  logic            saida_valida;
  logic            saida_pronta;
  logic [SELW-1:0] canal_saida;
  logic            erro_selecao;
  logic            limpa_erro;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [W-1:0] m_saida;
  logic         m_v;
  int           m_canal;
  logic         m_err;
  int           m_ptr;

  always #5 clock = ~clock;

  mux_n_registrado #(
    .LARGURA (W),
    .ENTRADAS(N)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .modo          (modo),
    .selecao       (selecao),
    .entradas      (entradas),
    .entrada_valida(entrada_valida),
    .entrada_pronta(entrada_pronta),
    .saida         (saida),
    .saida_valida  (saida_valida),
    .saida_pronta  (saida_pronta),
    .canal_saida   (canal_saida),
    .erro_selecao  (erro_selecao),
    .limpa_erro    (limpa_erro)
  );

  task automatic model_reset();
    m_saida = '0;
    m_v     = 1'b0;
    m_canal = 0;
    m_err   = 1'b0;
    m_ptr   = N - 1;
  endtask

  // Channel that wins under the current inputs, or -1 for none.
  function automatic int model_grant();
    if (modo == 1'b0) begin
      if (int'(selecao) < N && entrada_valida[selecao]) return int'(selecao);
      return -1;
    end
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (entrada_valida[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_pronta();
    int g;
    logic [N-1:0] one;
    one = 1;
    g = model_grant();
    if (reset && (!m_v || saida_pronta) && g >= 0) return one << g;
    return '0;
  endfunction

  function automatic logic [W-1:0] chan_data(input int c);
    return entradas[c*W +: W];
  endfunction

  task automatic randomize_data();
    for (int i = 0; i < N; i++) entradas[i*W +: W] = $urandom;
  endtask

  // Advance the model by one clock edge using the current inputs, then
  // move to the next falling edge where outputs are sampled.
  task automatic tick();
    int g;
    logic xfer;
    g = model_grant();
    xfer = reset && (!m_v || saida_pronta) && g >= 0;
    if (!reset) begin
      model_reset();
    end else begin
      if (modo == 1'b0 && int'(selecao) >= N && entrada_valida != '0) m_err = 1'b1;
      else if (limpa_erro) m_err = 1'b0;
      if (xfer) begin
        m_saida = chan_data(g);
        m_canal = g;
        m_v     = 1'b1;
        if (modo) m_ptr = g;
      end else if (m_v && saida_pronta) begin
        m_v = 1'b0;
      end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0; modo = 1'b0; selecao = '0; entrada_valida = '1;
    saida_pronta = 1'b1; limpa_erro = 1'b0;
    randomize_data();
    model_reset();
    @(negedge clock); @(negedge clock);
    #1;
    checks++; if (saida !== '0) begin failures++; $display("FAIL reset_saida got=%h exp=0", saida); end
    checks++; if (saida_valida !== 1'b0) begin failures++; $display("FAIL reset_valida got=%b exp=0", saida_valida); end
    checks++; if (canal_saida !== '0) begin failures++; $display("FAIL reset_canal got=%0d exp=0", canal_saida); end
    checks++; if (erro_selecao !== 1'b0) begin failures++; $display("FAIL reset_erro got=%b exp=0", erro_selecao); end
    checks++; if (entrada_pronta !== 3'b000) begin failures++; $display("FAIL reset_pronta got=%b exp=000", entrada_pronta); end
    @(negedge clock);
    reset = 1'b1; selecao = 2'd1;
    #1;
    checks++; if (entrada_pronta !== 3'b010) begin failures++; $display("FAIL first_pronta got=%b exp=010", entrada_pronta); end
    tick();
    checks++; if (saida_valida !== 1'b1 || saida !== m_saida || canal_saida !== 2'd1) begin
      failures++; $display("FAIL first_word got=%b/%h/%0d exp=1/%h/1", saida_valida, saida, canal_saida, m_saida);
    end
  endtask

  task automatic test_direct();
    modo = 1'b0; selecao = 2'd2; entrada_valida = 3'b111; saida_pronta = 1'b1;
    randomize_data();
    entradas[2*W +: W] = 32'hDEADBEEF;
    #1;
    checks++; if (entrada_pronta !== 3'b100) begin failures++; $display("FAIL direct_pronta got=%b exp=100", entrada_pronta); end
    tick();
    checks++; if (saida !== 32'hDEADBEEF || canal_saida !== 2'd2 || saida_valida !== 1'b1) begin
      failures++; $display("FAIL direct_word got=%h/%0d/%b exp=deadbeef/2/1", saida, canal_saida, saida_valida);
    end
    for (int n = 0; n < 40; n++) begin
      selecao = SELW'($urandom_range(0, 3));
      entrada_valida = N'($urandom);
      saida_pronta = ($urandom_range(0, 3) != 0);
      limpa_erro = ($urandom_range(0, 4) == 0);
      randomize_data();
      #1;
      checks++; if (entrada_pronta !== exp_pronta()) begin failures++; $display("FAIL direct_rand_pronta got=%b exp=%b", entrada_pronta, exp_pronta()); end
      tick();
      checks++; if (saida_valida !== m_v || saida !== m_saida || int'(canal_saida) != m_canal || erro_selecao !== m_err) begin
        failures++; $display("FAIL direct_rand_out got=%b/%h/%0d/%b exp=%b/%h/%0d/%b",
          saida_valida, saida, canal_saida, erro_selecao, m_v, m_saida, m_canal, m_err);
      end
    end
    limpa_erro = 1'b0;
  endtask

  task automatic test_out_of_range();
    modo = 1'b0; limpa_erro = 1'b1; selecao = 2'd0; entrada_valida = 3'b001; saida_pronta = 1'b1;
    randomize_data();
    tick();
    checks++; if (erro_selecao !== 1'b0 || saida_valida !== 1'b1) begin failures++; $display("FAIL oor_setup got=%b/%b exp=0/1", erro_selecao, saida_valida); end
    limpa_erro = 1'b0; selecao = 2'd3;
    #1;
    checks++; if (entrada_pronta !== 3'b000) begin failures++; $display("FAIL oor_pronta got=%b exp=000", entrada_pronta); end
    tick();
    checks++; if (erro_selecao !== 1'b1 || saida_valida !== 1'b0) begin failures++; $display("FAIL oor_err got=%b/%b exp=1/0", erro_selecao, saida_valida); end
    tick();
    checks++; if (erro_selecao !== 1'b1) begin failures++; $display("FAIL oor_sticky got=%b exp=1", erro_selecao); end
    limpa_erro = 1'b1; selecao = 2'd0; entrada_valida = 3'b000;
    tick();
    checks++; if (erro_selecao !== 1'b0) begin failures++; $display("FAIL oor_clear got=%b exp=0", erro_selecao); end
    limpa_erro = 1'b0;
  endtask

  task automatic test_round_robin();
    int seq_a[6] = '{0, 1, 2, 0, 1, 2};
    int seq_b[4] = '{0, 2, 0, 2};
    logic [N-1:0] one;
    logic [W-1:0] d;
    one = 1;
    modo = 1'b1; entrada_valida = 3'b111; saida_pronta = 1'b1; limpa_erro = 1'b0;
    for (int i = 0; i < 6; i++) begin
      randomize_data();
      d = chan_data(seq_a[i]);
      #1;
      checks++; if (entrada_pronta !== (one << seq_a[i])) begin failures++; $display("FAIL rr_pronta[%0d] got=%b exp=%b", i, entrada_pronta, one << seq_a[i]); end
      tick();
      checks++; if (int'(canal_saida) != seq_a[i] || saida !== d || saida_valida !== 1'b1) begin
        failures++; $display("FAIL rr_seq[%0d] got=%0d/%h/%b exp=%0d/%h/1", i, canal_saida, saida, saida_valida, seq_a[i], d);
      end
    end
    entrada_valida = 3'b101;
    for (int i = 0; i < 4; i++) begin
      randomize_data();
      d = chan_data(seq_b[i]);
      tick();
      checks++; if (int'(canal_saida) != seq_b[i] || saida !== d) begin
        failures++; $display("FAIL rr_skip[%0d] got=%0d/%h exp=%0d/%h", i, canal_saida, saida, seq_b[i], d);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    logic [SELW-1:0] held_c;
    int nxt;
    modo = 1'b1; entrada_valida = 3'b111; saida_pronta = 1'b1;
    randomize_data();
    tick();
    held = saida; held_c = canal_saida;
    checks++; if (saida_valida !== 1'b1 || saida !== m_saida) begin failures++; $display("FAIL bp_load got=%b/%h exp=1/%h", saida_valida, saida, m_saida); end
    saida_pronta = 1'b0;
    for (int i = 0; i < 4; i++) begin
      randomize_data();
      #1;
      checks++; if (entrada_pronta !== 3'b000) begin failures++; $display("FAIL bp_pronta[%0d] got=%b exp=000", i, entrada_pronta); end
      tick();
      checks++; if (saida !== held || canal_saida !== held_c || saida_valida !== 1'b1) begin
        failures++; $display("FAIL bp_stable[%0d] got=%h/%0d/%b exp=%h/%0d/1", i, saida, canal_saida, saida_valida, held, held_c);
      end
    end
    saida_pronta = 1'b1;
    randomize_data();
    nxt = (int'(held_c) + 1) % N;
    #1;
    checks++; if (entrada_pronta === 3'b000 || entrada_pronta !== exp_pronta()) begin failures++; $display("FAIL bp_release_pronta got=%b exp=%b", entrada_pronta, exp_pronta()); end
    tick();
    checks++; if (int'(canal_saida) != nxt || saida !== m_saida || saida_valida !== 1'b1) begin
      failures++; $display("FAIL bp_release got=%0d/%h/%b exp=%0d/%h/1", canal_saida, saida, saida_valida, nxt, m_saida);
    end
  endtask

  task automatic test_simultaneous();
    modo = 1'b0; selecao = 2'd3; entrada_valida = 3'b010; limpa_erro = 1'b1; saida_pronta = 1'b1;
    tick();
    checks++; if (erro_selecao !== 1'b1) begin failures++; $display("FAIL clear_vs_error got=%b exp=1", erro_selecao); end
    limpa_erro = 1'b0; selecao = 2'd1;
    randomize_data();
    tick();
    saida_pronta = 1'b0;
    checks++; if (saida_valida !== 1'b1) begin failures++; $display("FAIL pre_reset_valid got=%b exp=1", saida_valida); end
    #2 reset = 1'b0;
    #1;
    model_reset();
    checks++; if (saida_valida !== 1'b0 || saida !== '0 || canal_saida !== '0 || erro_selecao !== 1'b0 || entrada_pronta !== '0) begin
      failures++; $display("FAIL async_reset got=%b/%h/%0d/%b/%b exp=0/0/0/0/000", saida_valida, saida, canal_saida, erro_selecao, entrada_pronta);
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_random_mixed();
    for (int n = 0; n < 300; n++) begin
      modo = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      selecao = SELW'($urandom_range(0, 3));
      entrada_valida = N'($urandom);
      saida_pronta = ($urandom_range(0, 3) != 0);
      limpa_erro = ($urandom_range(0, 5) == 0);
      randomize_data();
      #1;
      checks++; if (entrada_pronta !== exp_pronta()) begin failures++; $display("FAIL mixed_pronta[%0d] got=%b exp=%b", n, entrada_pronta, exp_pronta()); end
      tick();
      checks++; if (saida_valida !== m_v || saida !== m_saida || int'(canal_saida) != m_canal || erro_selecao !== m_err) begin
        failures++; $display("FAIL mixed_out[%0d] got=%b/%h/%0d/%b exp=%b/%h/%0d/%b",
          n, saida_valida, saida, canal_saida, erro_selecao, m_v, m_saida, m_canal, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_out_of_range();
    test_round_robin();
    test_backpressure();
    test_simultaneous();
    test_random_mixed();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
